// File: rtl/game_palette_pkg.sv
// Shared types and default-palette data for the 2048 renderer colour LUT.
package game_palette_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_FADE = 2'd2
  } state_t;

  localparam int DEF_ENTRIES = 8;

  // Standard game palette, 4 bits per channel, {r,g,b}.
  localparam logic [11:0] DEF_TABLE [DEF_ENTRIES] = '{
    12'hEEE, 12'hCCB, 12'hA99, 12'h666,
    12'hCBA, 12'hA99, 12'hBBA, 12'h887
  };

  function automatic logic [11:0] default_entry(input int k);
    if (k >= 0 && k < DEF_ENTRIES) begin
      return DEF_TABLE[k[2:0]];
    end
    return 12'h000;
  endfunction

  // Left-justify a 4-bit default channel into a wider channel, zero-filled.
  function automatic logic [7:0] widen_ch(input logic [3:0] v, input int ch_w);
    logic [7:0] w;
    w = {4'h0, v};
    return w << (ch_w - 4);
  endfunction

endpackage

// File: rtl/palette_fader.sv
// Brightness level register and the INIT/IDLE/FADE control FSM of the palette LUT.
module palette_fader
  import game_palette_pkg::*;
#(
  parameter int CH_W      = 4,
  parameter int FADE_STEP = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_init_last,
  input  logic          i_fade_start,
  input  logic          i_fade_dir,
  output state_t        o_state,
  output logic [CH_W:0] o_level,
  output logic          o_fade_busy
);

  localparam int              CNT_W    = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_STEP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CH_W:0]   LVL_FULL = {1'b1, {CH_W{1'b0}}};
  localparam logic [CH_W:0]   LVL_ONE  = (CH_W + 1)'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CH_W:0]    r_level;
  logic [CH_W:0]    w_level_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic [CH_W:0]    w_target;
  logic [CH_W:0]    w_level_step;

  assign w_target     = r_dir ? LVL_FULL : '0;
  assign w_level_step = r_dir ? (r_level + LVL_ONE) : (r_level - LVL_ONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_INIT;
      r_level <= LVL_FULL;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    case (r_state)
      ST_INIT: begin
        if (i_init_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (i_fade_start) begin
          w_state_nxt = ST_FADE;
          w_dir_nxt   = i_fade_dir;
          w_cnt_nxt   = '0;
        end
      end
      ST_FADE: begin
        // A fade requested at its own target ends after one busy cycle.
        if (r_level == w_target) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_level_nxt = w_level_step;
          if (w_level_step == w_target) begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  assign o_state     = r_state;
  assign o_level     = r_level;
  assign o_fade_busy = (r_state == ST_FADE);

endmodule

// File: rtl/game_palette_lut.sv
// Programmable, fadeable palette LUT: self-loading RAM, write port, 2-stage scaled read.
module game_palette_lut
  import game_palette_pkg::*;
#(
  parameter int IDX_W     = 3,
  parameter int CH_W      = 4,
  parameter int FADE_STEP = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              rd_valid,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              out_valid,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic              fade_start,
  input  logic              fade_dir,
  output logic              fade_busy,
  output logic              init_done,
  output state_t            dbg_state
);

  localparam int PW    = 2 * CH_W + 1;
  localparam int DEPTH = 1 << IDX_W;

  // Handshake: a write is taken on any rising edge where wr_valid && wr_ready;
  // wr_ready is high only in IDLE. Reads have no handshake and are never stalled.

  logic [3*CH_W-1:0] r_ram [DEPTH];
  logic [IDX_W-1:0]  r_init_cnt;
  logic              r_s1_valid;
  logic [3*CH_W-1:0] r_s1_rgb;
  logic              r_out_valid;
  logic [CH_W-1:0]   r_red;
  logic [CH_W-1:0]   r_green;
  logic [CH_W-1:0]   r_blue;

  state_t            w_state;
  logic [CH_W:0]     w_level;
  logic              w_init_last;
  logic              w_wr_fire;
  logic [11:0]       w_def_entry;
  logic [3*CH_W-1:0] w_def_rgb;
  logic [PW-1:0]     w_prod_r;
  logic [PW-1:0]     w_prod_g;
  logic [PW-1:0]     w_prod_b;

  palette_fader #(
    .CH_W      (CH_W),
    .FADE_STEP (FADE_STEP)
  ) u_fader (
    .i_clk        (Clk),
    .i_rst_n      (Reset_n),
    .i_init_last  (w_init_last),
    .i_fade_start (fade_start),
    .i_fade_dir   (fade_dir),
    .o_state      (w_state),
    .o_level      (w_level),
    .o_fade_busy  (fade_busy)
  );

  assign w_init_last = (r_init_cnt == IDX_W'(DEPTH - 1));
  assign w_wr_fire   = wr_valid && wr_ready;
  assign wr_ready    = (w_state == ST_IDLE);
  assign init_done   = (w_state != ST_INIT);
  assign dbg_state   = w_state;

  assign w_def_entry = default_entry(int'(r_init_cnt));
  assign w_def_rgb   = {CH_W'(widen_ch(w_def_entry[11:8], CH_W)),
                        CH_W'(widen_ch(w_def_entry[7:4],  CH_W)),
                        CH_W'(widen_ch(w_def_entry[3:0],  CH_W))};

  // Palette RAM; reads in stage 1 see the contents before this edge's write.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ram[i] <= '0;
      end
    end else if (w_state == ST_INIT) begin
      r_ram[r_init_cnt] <= w_def_rgb;
    end else if (w_wr_fire) begin
      r_ram[wr_idx] <= wr_rgb;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_init_cnt <= '0;
    end else if (w_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + IDX_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_rgb   <= '0;
    end else begin
      r_s1_valid <= rd_valid;
      r_s1_rgb   <= r_ram[rd_idx];
    end
  end

  // Full-width products so level == 2**CH_W is an exact identity.
  assign w_prod_r = PW'(r_s1_rgb[3*CH_W-1 -: CH_W]) * PW'(w_level);
  assign w_prod_g = PW'(r_s1_rgb[2*CH_W-1 -: CH_W]) * PW'(w_level);
  assign w_prod_b = PW'(r_s1_rgb[CH_W-1:0])         * PW'(w_level);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid <= 1'b0;
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_red   <= CH_W'(w_prod_r >> CH_W);
        r_green <= CH_W'(w_prod_g >> CH_W);
        r_blue  <= CH_W'(w_prod_b >> CH_W);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign red       = r_red;
  assign green     = r_green;
  assign blue      = r_blue;

endmodule

// File: doc/game_palette_lut.md
# game_palette_lut

Programmable, fadeable colour-lookup table for the 2048 game renderer. It sits between the sprite/tile index fetch and the VGA colour output. It maps a pixel's palette index to RGB through a two-stage read pipeline and supports runtime rewrites of palette entries. A global brightness level can ramp, giving screen fade-in/fade-out on game start and game over. After reset it self-loads the standard 8-colour game palette before accepting writes.

## Interface
Parameters:
- IDX_W, 3: index width; depth = 2**IDX_W entries.
- CH_W, 4: bits per colour channel; legal range 4..8.
- FADE_STEP, 4: cycles per brightness step while fading; must be ≥1.

Ports:
- Clk  in  1  system clock; all logic is on its rising edge.
- Reset_n  in  1  reset, asynchronous and active-low.
- rd_valid  in  1  read request qualifier.
- rd_idx  in  IDX_W  palette index to look up.
- out_valid  out  1  rd_valid delayed by 2 cycles.
- red, green, blue  out  CH_W each  scaled colour for the request issued 2 cycles earlier.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_idx  in  IDX_W  entry to overwrite.
- wr_rgb  in  3*CH_W  {r,g,b}, with r in the MSBs.
- fade_start  in  1  one-cycle pulse that begins a fade.
- fade_dir  in  1  sampled with fade_start: 0 = toward black, 1 = toward full.
- fade_busy  out  1  high while a fade is in progress.
- init_done  out  1  high once the default load completes; stays high until reset.

## Operation
State machine:
- INIT: after reset, entry k is written with its default at the k-th cycle, for k = 0..2**IDX_W−1. Moves to IDLE after the last entry.
- IDLE: wr_ready=1. Moves to FADE on fade_start.
- FADE: wr_ready=0, so writes stall. Moves back to IDLE when level reaches its target.

Default table, stated as 4-bit r,g,b:
- Entry 0: E,E,E. Entry 1: C,C,B. Entry 2: A,9,9. Entry 3: 6,6,6.
- Entry 4: C,B,A. Entry 5: A,9,9. Entry 6: B,B,A. Entry 7: 8,8,7.
- For CH_W>4, each value is left-shifted by CH_W−4 and zero-filled.
- Entries ≥8 default to 0. When IDX_W<3, only the first 2**IDX_W entries exist.

Brightness and fading:
- level has width CH_W+1, range 0..2**CH_W. Reset value is 2**CH_W (full).
- Output channel = (ch × level) >> CH_W, computed at full product width then truncated. level = 2**CH_W is the identity; level = 0 gives black.
- In FADE, level moves by ±1 every FADE_STEP cycles toward 0 (fade_dir=0) or toward 2**CH_W (fade_dir=1).
- A fade already at its target completes in 1 cycle with level unchanged.
- fade_start is ignored in INIT and in FADE.
- After a fade-out completes, level stays at 0 until the next fade-in.

Reads:
- Reads are accepted in every state. There is no backpressure.
- During INIT, a read returns the current RAM content; entries not yet loaded read as 0.

## Timing
- Reset values: out_valid=0, red=green=blue=0, wr_ready=0, fade_busy=0, init_done=0. State=INIT, level=2**CH_W, RAM cleared.
- Read latency is exactly 2 cycles. Stage 1 registers the RAM data and rd_valid. Stage 2 applies level and registers the outputs.
- The level used for a read is the value sampled in stage 2.
- When out_valid=0, the outputs hold their last values.
- Write takes effect at the clock edge of acceptance.
- A read and a write to the same index in the same cycle return the old value (read-before-write). A read to that index issued the next cycle returns the new value.
- init_done rises at the edge where the last default entry is written; wr_ready rises the same cycle.
- A fade lasting N steps keeps fade_busy high for N×FADE_STEP cycles. fade_busy rises the cycle after fade_start.
- Reset_n asserted mid-fade or mid-INIT immediately restores all reset values. INIT then restarts from entry 0.

## Structure
- Package game_palette_pkg holds:
  - the state enum (INIT, IDLE, FADE);
  - the 8-entry 4-bit default table constant;
  - a function that widens a default entry to CH_W.
- Sub-module palette_fader holds the level register, the step counter, and the fade FSM bits. It outputs level and fade_busy.
- The top level holds the RAM, the INIT counter, the write handshake, and the 2-stage read pipeline.

## Test plan
- Release reset with default parameters, then wait for init_done (8 cycles). Read indices 0..7 back-to-back: out_valid pulses 2 cycles after each read, returning E,E,E / C,C,B / A,9,9 / 6,6,6 / C,B,A / A,9,9 / B,B,A / 8,8,7.
- Write idx 3 = F,0,0 while reading idx 3 in the same cycle: that read returns 6,6,6. A read the next cycle returns F,0,0.
- Pulse fade_start with fade_dir=0 and FADE_STEP=4: fade_busy stays high for 64 cycles and wr_ready is 0 throughout. Reading idx 0 at level 8 returns 7,7,7; at the end, reading idx 0 returns 0,0,0.
- Pulse fade_start with fade_dir=1 from level 0: after 64 cycles the level is full and idx 0 reads E,E,E. A second fade_start during the fade is ignored.
- With CH_W=8 and IDX_W=4: idx 1 reads C0,C0,B0 and idx 12 reads 00,00,00.
- Assert Reset_n mid-fade: outputs and fade_busy drop to 0 asynchronously. init_done stays 0 until INIT completes again, after which idx 3 reads 6,6,6.
